// File: rtl/sig_ctrl_pkg.sv
// Shared light encodings, controller phase enum and the serving-index width helper.
package sig_ctrl_pkg;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

    typedef enum logic [2:0] {
        MAIN_GREEN = 3'd0,
        MAIN_YEL   = 3'd1,
        RED_A      = 3'd2,
        CH_GREEN   = 3'd3,
        CH_YEL     = 3'd4,
        RED_B      = 3'd5
    } phase_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly above i_last, else the lowest set one.
module rr_arbiter
    import sig_ctrl_pkg::*;
#(
    parameter int   N_CH  = 2,
    localparam int  IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic             w_hi_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic             w_lo_found;
    logic [IDX_W-1:0] w_lo_idx;

    // Scan downward so the last hit is the lowest index, both above i_last and overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDX_W'(j);
                if (j > int'(i_last)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(j);
                end
            end
        end
        o_valid = w_lo_found;
        o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    end

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// Intersection sequencer: main phase rests green, latched secondary demand is served
// one channel per cycle-out in round-robin order, with yellow and all-red clearance.
//
//   state      | meaning
//   MAIN_GREEN | main green, waits for min green and any pending demand
//   MAIN_YEL   | main yellow
//   RED_A      | all-red before the selected channel
//   CH_GREEN   | selected channel green (fixed for ped, detector-extended for road)
//   CH_YEL     | selected channel yellow
//   RED_B      | all-red before returning to main green
module multi_phase_signal_ctrl
    import sig_ctrl_pkg::*;
#(
    parameter int         N_CH      = 2,
    parameter logic [7:0] PED_MASK  = 8'b0000_0010,
    parameter int         CNT_W     = 5,
    parameter int         MIN_GREEN = 6,
    parameter int         MAX_GREEN = 15,
    parameter int         YELLOW_T  = 3,
    parameter int         ALL_RED_T = 1,
    localparam int        IDX_W     = idx_w(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [N_CH-1:0]     req_level,
    input  logic [N_CH-1:0]     req_pulse,
    output logic [1:0]          main_state,
    output logic [2*N_CH-1:0]   ch_state,
    output logic [IDX_W-1:0]    serving,
    output logic [N_CH-1:0]     pending
);

    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $error("multi_phase_signal_ctrl: N_CH must be 1..8");
    end
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_T < 1 || ALL_RED_T < 0) begin : g_bad_time
        $error("multi_phase_signal_ctrl: inconsistent phase durations");
    end
    if (MIN_GREEN >= (1 << CNT_W) || MAX_GREEN >= (1 << CNT_W) ||
        YELLOW_T >= (1 << CNT_W) || ALL_RED_T >= (1 << CNT_W)) begin : g_bad_width
        $error("multi_phase_signal_ctrl: duration does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_M1   = CNT_W'(ALL_RED_T - 1);
    localparam bit               SKIP_RED = (ALL_RED_T == 0);
    localparam logic [N_CH-1:0]  PED      = PED_MASK[N_CH-1:0];

    phase_e             r_state;
    phase_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_CH-1:0]    r_pending;
    logic [N_CH-1:0]    w_pending_nxt;
    logic [IDX_W-1:0]   r_serving;
    logic [IDX_W-1:0]   w_serving_nxt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [1:0]         r_main_state;
    logic [1:0]         w_main_nxt;
    logic [2*N_CH-1:0]  r_ch_state;
    logic [2*N_CH-1:0]  w_ch_nxt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic               w_green_done;
    logic [N_CH-1:0]    w_ch_green;
    logic [N_CH-1:0]    w_set;
    logic [N_CH-1:0]    w_clr;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req   (r_pending),
        .i_last  (r_last),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Green termination for the channel in service: peds run fixed, roads extend on detector.
    always_comb begin
        w_green_done = 1'b0;
        if (PED[r_serving]) begin
            w_green_done = (r_cnt == MIN_M1);
        end else begin
            w_green_done = ((r_cnt >= MIN_M1) && !req_level[r_serving]) || (r_cnt == MAX_M1);
        end
    end

    // Next-state, serving latch and round-robin history; every move is qualified by tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_serving_nxt = r_serving;
        w_last_nxt    = r_last;
        if (tick) begin
            unique case (r_state)
                MAIN_GREEN: begin
                    if (r_cnt >= MIN_M1 && w_arb_valid) begin
                        w_state_nxt   = MAIN_YEL;
                        w_serving_nxt = w_arb_idx;
                    end
                end
                MAIN_YEL: begin
                    if (r_cnt == YEL_M1) begin
                        if (SKIP_RED) w_state_nxt = CH_GREEN;
                        else          w_state_nxt = RED_A;
                    end
                end
                RED_A: begin
                    if (r_cnt == RED_M1) w_state_nxt = CH_GREEN;
                end
                CH_GREEN: begin
                    if (w_green_done) w_state_nxt = CH_YEL;
                end
                CH_YEL: begin
                    if (r_cnt == YEL_M1) begin
                        if (SKIP_RED) begin
                            w_state_nxt = MAIN_GREEN;
                            w_last_nxt  = r_serving;
                        end else begin
                            w_state_nxt = RED_B;
                        end
                    end
                end
                RED_B: begin
                    if (r_cnt == RED_M1) begin
                        w_state_nxt = MAIN_GREEN;
                        w_last_nxt  = r_serving;
                    end
                end
                default: w_state_nxt = MAIN_GREEN;
            endcase
        end
    end

    // Demand latches: set by button or road detector unless that channel is green; entry clear wins.
    always_comb begin
        w_ch_green = '0;
        w_set      = '0;
        w_clr      = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ch_green[i] = (r_state == CH_GREEN) && (r_serving == IDX_W'(i));
            w_set[i]      = (req_pulse[i] | (req_level[i] & ~PED[i])) & ~w_ch_green[i];
            w_clr[i]      = (w_state_nxt == CH_GREEN) && (r_state != CH_GREEN) &&
                            (r_serving == IDX_W'(i));
        end
        w_pending_nxt = (r_pending | w_set) & ~w_clr;
    end

    // Light outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        w_main_nxt = LT_RED;
        w_ch_nxt   = '0;
        if (w_state_nxt == MAIN_GREEN) w_main_nxt = LT_GRN;
        if (w_state_nxt == MAIN_YEL)   w_main_nxt = LT_YEL;
        for (int i = 0; i < N_CH; i++) begin
            if (w_serving_nxt == IDX_W'(i)) begin
                if (w_state_nxt == CH_GREEN) w_ch_nxt[2*i +: 2] = LT_GRN;
                if (w_state_nxt == CH_YEL)   w_ch_nxt[2*i +: 2] = LT_YEL;
            end
        end
    end

    // State, selection history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= MAIN_GREEN;
            r_serving    <= '0;
            r_last       <= IDX_W'(N_CH - 1);
            r_pending    <= '0;
            r_main_state <= LT_GRN;
            r_ch_state   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_serving    <= w_serving_nxt;
            r_last       <= w_last_nxt;
            r_pending    <= w_pending_nxt;
            r_main_state <= w_main_nxt;
            r_ch_state   <= w_ch_nxt;
        end
    end

    // Phase timer: cleared on any state change, counts ticks, holds at the main minimum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (tick && !(r_state == MAIN_GREEN && r_cnt >= MIN_M1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign main_state = r_main_state;
    assign ch_state   = r_ch_state;
    assign serving    = r_serving;
    assign pending    = r_pending;

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Scoreboard bench: predicted light changes (pattern + tick number) are queued when
// stimulus is applied and matched against every observed change of the light outputs.
module tb_multi_phase_signal_ctrl;
    import sig_ctrl_pkg::*;

    localparam int N     = 2;
    localparam int MIN_G = 6;
    localparam int MAX_G = 15;
    localparam int YEL_T = 3;
    localparam int RED_T = 1;

    typedef struct {
        int         t;
        logic [5:0] pat;
    } exp_ev_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tick = 1'b0;
    logic [N-1:0]   req_level = '0;
    logic [N-1:0]   req_pulse = '0;
    logic [1:0]     main_state;
    logic [2*N-1:0] ch_state;
    logic [0:0]     serving;
    logic [N-1:0]   pending;

    exp_ev_t exp_q[$];
    int      n_total = 0;
    int      n_bad   = 0;
    int      tcount  = 0;
    int      tb_tick = 0;

    multi_phase_signal_ctrl #(
        .N_CH      (N),
        .PED_MASK  (8'b0000_0010),
        .CNT_W     (5),
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_T  (YEL_T),
        .ALL_RED_T (RED_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .req_level  (req_level),
        .req_pulse  (req_pulse),
        .main_state (main_state),
        .ch_state   (ch_state),
        .serving    (serving),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [5:0] mk(input logic [1:0] m, input int ch, input logic [1:0] cl);
        logic [5:0] v;
        v = {m, 4'b0000};
        if (ch >= 0) v[2*ch +: 2] = cl;
        return v;
    endfunction

    task automatic push_ev(input int t, input logic [5:0] pat);
        exp_ev_t e;
        e.t   = t;
        e.pat = pat;
        exp_q.push_back(e);
    endtask

    // One full cycle-out starting at tick t0 with a channel green of g ticks.
    task automatic push_cycle(input int t0, input int ch, input int g);
        push_ev(t0,                             mk(LT_YEL, -1, LT_RED));
        push_ev(t0 + YEL_T,                     mk(LT_RED, -1, LT_RED));
        push_ev(t0 + YEL_T + RED_T,             mk(LT_RED, ch, LT_GRN));
        push_ev(t0 + YEL_T + RED_T + g,         mk(LT_RED, ch, LT_YEL));
        push_ev(t0 + 2*YEL_T + RED_T + g,       mk(LT_RED, -1, LT_RED));
        push_ev(t0 + 2*YEL_T + 2*RED_T + g,     mk(LT_GRN, -1, LT_RED));
    endtask

    task automatic tick_once();
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        tb_tick++;
    endtask

    task automatic run_to(input int t);
        while (tb_tick < t) tick_once();
    endtask

    task automatic pulse(input logic [N-1:0] m);
        req_pulse = m;
        @(negedge clk);
        req_pulse = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        tick      = 1'b0;
        req_level = '0;
        req_pulse = '0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst     = 1'b0;
        tb_tick = 0;
    endtask

    // Monitor: counts ticks since reset and pops one prediction per observed light change.
    initial begin
        logic [5:0] cur;
        logic [5:0] prev;
        exp_ev_t    e;
        prev = '0;
        forever begin
            @(posedge clk);
            if (tick && !rst) tcount++;
            #1;
            cur = {main_state, ch_state};
            if (rst) begin
                tcount = 0;
                prev   = cur;
            end else if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_change", 32'(cur), 32'(prev));
                end else begin
                    e = exp_q.pop_front();
                    chk("light_pattern", 32'(cur), 32'(e.pat));
                    chk("change_tick", tcount, e.t);
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        // Idle: reset values, then 20 ticks with no demand and no light change.
        do_reset();
        @(negedge clk);
        chk("rst_main", 32'(main_state), 32'(LT_GRN));
        chk("rst_ch", 32'(ch_state), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_serving", 32'(serving), 0);
        run_to(20);
        chk("idle_main", 32'(main_state), 32'(LT_GRN));
        chk("idle_ch", 32'(ch_state), 0);
        chk("idle_drained", exp_q.size(), 0);

        // Pedestrian pulse on ch1 at tick 2; cycle-out once main minimum completes at tick 6.
        do_reset();
        run_to(2);
        push_cycle(6, 1, MIN_G);
        pulse(2'b10);
        chk("ped_pending", 32'(pending), 32'b10);
        run_to(6);
        chk("ped_serving", 32'(serving), 1);
        chk("ped_pend_held", 32'(pending), 32'b10);
        run_to(10);
        chk("ped_pend_clr", 32'(pending), 0);
        run_to(20);
        chk("ped_drained", exp_q.size(), 0);

        // Road ch0 detector held: green runs to the MAX_GREEN ceiling.
        req_level = 2'b01;
        push_cycle(26, 0, MAX_G);
        run_to(35);
        chk("road_no_set_green", 32'(pending), 0);
        run_to(45);
        req_level = 2'b00;
        run_to(49);
        chk("road_max_drained", exp_q.size(), 0);
        chk("road_max_pend", 32'(pending), 0);

        // Road ch0 detector dropped two ticks into green: green ends at the minimum.
        req_level = 2'b01;
        push_cycle(55, 0, MIN_G);
        run_to(59);
        chk("entry_clr_wins", 32'(pending), 0);
        run_to(61);
        req_level = 2'b00;
        run_to(71);
        chk("road_min_drained", exp_q.size(), 0);
        chk("road_min_pend", 32'(pending), 0);

        // Simultaneous demand: ch0 first, then ch1; re-requests give ch1 ahead of ch0.
        do_reset();
        run_to(1);
        pulse(2'b11);
        chk("both_pending", 32'(pending), 32'b11);
        push_cycle(6, 0, MIN_G);
        push_cycle(26, 1, MIN_G);
        push_cycle(46, 0, MIN_G);
        run_to(6);
        chk("rr_first", 32'(serving), 0);
        run_to(17);
        pulse(2'b11);
        chk("rr_relatch", 32'(pending), 32'b11);
        run_to(26);
        chk("rr_second", 32'(serving), 1);
        run_to(46);
        chk("rr_third", 32'(serving), 0);
        run_to(62);
        chk("rr_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a channel yellow.
        pulse(2'b10);
        push_ev(66, mk(LT_YEL, -1, LT_RED));
        push_ev(69, mk(LT_RED, -1, LT_RED));
        push_ev(70, mk(LT_RED, 1, LT_GRN));
        push_ev(76, mk(LT_RED, 1, LT_YEL));
        run_to(71);
        pulse(2'b01);
        run_to(77);
        chk("pre_rst_ch", 32'(ch_state), 32'b0100);
        chk("pre_rst_pend", 32'(pending), 32'b01);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_main", 32'(main_state), 32'(LT_GRN));
        chk("async_ch", 32'(ch_state), 0);
        chk("async_pend", 32'(pending), 0);
        chk("async_serving", 32'(serving), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        tb_tick = 0;
        run_to(8);
        chk("post_rst_pend", 32'(pending), 0);
        chk("post_rst_main", 32'(main_state), 32'(LT_GRN));
        chk("post_rst_drained", exp_q.size(), 0);

        // Tick held high on consecutive clocks: every edge counts as a tick.
        do_reset();
        pulse(2'b10);
        push_cycle(6, 1, MIN_G);
        tick = 1'b1;
        repeat (25) @(negedge clk);
        tick    = 1'b0;
        tb_tick = 25;
        @(negedge clk);
        chk("burst_drained", exp_q.size(), 0);
        chk("burst_main", 32'(main_state), 32'(LT_GRN));
        chk("burst_pend", 32'(pending), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
